// File: rtl/instr_encoder_pkg.sv
// Shared encoding vocabulary for the instruction encoder and its matching decoder:
// request kinds, base opcodes, error codes and an immediate-range helper.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ITYPE = 3'd4,
        KIND_JAL   = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_KIND  = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_ALIGN = 2'd3
    } err_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRX  = 3'b101;

    // True when v, read as two's complement, is representable in 'width' signed bits.
    function automatic logic simm_fits(input logic [31:0] v, input int unsigned width);
        logic [31:0] top;
        top = $unsigned($signed(v) >>> (width - 1));
        return (top == 32'h0000_0000) || (top == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packing and immediate legality check for one request.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output err_e        errcode_o
);

    logic [6:0] funct7;
    logic       is_shift;

    assign funct7   = {1'b0, funct7b5_i, 5'b00000};
    assign is_shift = (funct3_i == F3_SLL) || (funct3_i == F3_SRX);

    always_comb begin
        instr_o   = 32'h0000_0000;
        errcode_o = ERR_NONE;
        case (kind_i)
            KIND_LW: begin
                instr_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
                if (!simm_fits(imm_i, 12)) errcode_o = ERR_RANGE;
            end
            KIND_SW: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
                if (!simm_fits(imm_i, 12)) errcode_o = ERR_RANGE;
            end
            KIND_RTYPE: begin
                instr_o = {funct7, rs2_i, rs1_i, funct3_i, rd_i, OP_REG};
            end
            KIND_ITYPE: begin
                if (is_shift) begin
                    instr_o = {funct7, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_IMM};
                    if (imm_i[31:5] != 27'd0) errcode_o = ERR_RANGE;
                end else begin
                    instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
                    if (!simm_fits(imm_i, 12)) errcode_o = ERR_RANGE;
                end
            end
            KIND_BEQ: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                // Alignment is judged before range, so an odd far target reports misaligned.
                if (imm_i[0])                   errcode_o = ERR_ALIGN;
                else if (!simm_fits(imm_i, 13)) errcode_o = ERR_RANGE;
            end
            KIND_JAL: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                if (imm_i[0])                   errcode_o = ERR_ALIGN;
                else if (!simm_fits(imm_i, 21)) errcode_o = ERR_RANGE;
            end
            default: errcode_o = ERR_KIND;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into instruction memory through a one-entry output
// register, tracking write address, written-word count and the first encoding error.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic [1:0]  errcode_o,
    output logic [15:0] count_o
);

    // Handshakes: a request moves when valid_i && ready_o at a rising edge, a word
    // moves when wvalid_o && wready_i; wvalid_o and its payload never change while
    // the word waits, and a clear in the same cycle wins over both.

    logic        wvalid_q, wvalid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    err_e        code_q, code_d;

    logic [31:0] pack_instr;
    err_e        pack_err;
    logic        wr_fire;
    logic        req_fire;

    instr_pack u_pack (
        .kind_i     (kind_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .instr_o    (pack_instr),
        .errcode_o  (pack_err)
    );

    assign ready_o  = !clear_i && (!wvalid_q || wready_i);
    assign wr_fire  = wvalid_q && wready_i;
    assign req_fire = valid_i && ready_o;

    always_comb begin
        wvalid_d = wvalid_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        code_d   = code_q;
        if (clear_i) begin
            wvalid_d = 1'b0;
            addr_d   = 32'h0000_0000;
            count_d  = 16'h0000;
            err_d    = 1'b0;
            code_d   = ERR_NONE;
        end else begin
            if (wr_fire) begin
                wvalid_d = 1'b0;
                addr_d   = addr_q + 32'd4;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            end
            if (req_fire) begin
                if (pack_err == ERR_NONE) begin
                    wvalid_d = 1'b1;
                    instr_d  = pack_instr;
                end else begin
                    err_d = 1'b1;
                    if (!err_q) code_d = pack_err;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wvalid_q <= 1'b0;
            instr_q  <= 32'h0000_0000;
            addr_q   <= 32'h0000_0000;
            count_q  <= 16'h0000;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            wvalid_q <= wvalid_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign wvalid_o  = wvalid_q;
    assign instr_o   = instr_q;
    assign addr_o    = addr_q;
    assign count_o   = count_q;
    assign err_o     = err_q;
    assign errcode_o = code_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port clear_i  input  1  synchronous soft clear of address, count, error and pending word.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  request accepted when valid_i && ready_o.
REQ-006 SHALL have port kind_i  input  3  0=LW, 1=SW, 2=RTYPE, 3=BEQ, 4=ITYPE, 5=JAL, 6..7 illegal.
REQ-007 SHALL have ports funct3_i  input  3 and funct7b5_i  input  1  ALU function select (RTYPE/ITYPE only).
REQ-008 SHALL have ports rd_i, rs1_i, rs2_i  input  5 each  register indices.
REQ-009 SHALL have port imm_i  input  32  signed immediate / byte offset.
REQ-010 SHALL have port wvalid_o  output  1  instruction-memory write valid.
REQ-011 SHALL have port wready_i  input  1  memory accepts word when wvalid_o && wready_i.
REQ-012 SHALL have ports instr_o  output  32 and addr_o  output  32  encoded word and its byte address.
REQ-013 SHALL have ports err_o  output  1 (sticky) and errcode_o  output  2  (0 none, 1 illegal kind, 2 imm range, 3 misaligned).
REQ-014 SHALL have port count_o  output  16  words written, saturating at 0xFFFF.

Function
REQ-015 SHALL hold one output register; ready_o = !wvalid_o || wready_i, combinational.
REQ-016 SHALL present an accepted legal request on instr_o with wvalid_o=1 on the next cycle (latency 1); full throughput when wready_i=1.
REQ-017 SHALL hold instr_o, addr_o, wvalid_o stable while wvalid_o && !wready_i.
REQ-018 SHALL increment the address by 4 on each write handshake, modulo 2^32; addr_o shows the address of the current word.
REQ-019 SHALL increment count_o on each write handshake, saturating at 0xFFFF.
REQ-020 SHALL encode LW as imm[11:0]|rs1|010|rd|0000011; SW as imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
REQ-021 SHALL encode RTYPE as {0,funct7b5,00000}|rs2|rs1|funct3|rd|0110011.
REQ-022 SHALL encode ITYPE as imm[11:0]|rs1|funct3|rd|0010011; for funct3=001/101 the upper 7 bits SHALL be {0,funct7b5,00000} with shamt=imm[4:0].
REQ-023 SHALL encode BEQ as imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011; JAL as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
REQ-024 SHALL range-check: LW/SW/ITYPE imm in [-2048,2047]; shifts imm in [0,31]; BEQ in [-4096,4094]; JAL in [-2^20,2^20-2].
REQ-025 SHALL flag BEQ/JAL odd imm as misaligned (code 3) before range check.
REQ-026 SHALL, on illegal request, complete the input handshake, emit no word, leave address and count unchanged, set err_o=1, and latch errcode_o of the first error only.
REQ-027 SHALL give clear_i priority over any handshake in the same cycle: address 0, count 0, err cleared, pending word dropped, ready_o=0 that cycle.

Reset
REQ-028 SHALL on rst_i=1 set wvalid_o=0, instr_o=0, addr_o=0, count_o=0, err_o=0, errcode_o=0; ready_o then reads 1.
REQ-029 SHALL on reset mid-operation discard the pending word without a write handshake.

Structure
REQ-030 SHALL place kind enum, opcode constants and error-code enum in a shared package used also by the decoder side.
REQ-031 SHALL implement encoding and range checking in one combinational sub-module instr_pack; instr_encoder holds handshake, address, count and error state.

Verification
REQ-032 RTYPE rd=3 rs1=1 rs2=2 funct3=0 funct7b5=0 -> instr_o=0x002081B3, addr_o=0 next cycle.
REQ-033 LW rd=5 rs1=2 imm=8, then SW rs2=5 rs1=2 imm=12 back-to-back -> 0x00812283 @0, 0x00512623 @4, count_o=2.
REQ-034 BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=16 -> 0x010000EF.
REQ-035 BEQ imm=3 -> err_o=1, errcode_o=3, no wvalid_o, address unchanged; subsequent ITYPE imm=4096 keeps errcode_o=3.
REQ-036 wready_i low 3 cycles with word pending -> instr_o/addr_o stable, ready_o=0; clear_i asserted then -> wvalid_o=0, addr_o=0, count_o=0.
